// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, tap-shift lookup and approximate-adder reference for the shift-and-add FIR
package fir_pkg;
   localparam int SW = 4;
   localparam logic [19:0] SHIFT_DEF = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
   function automatic int unsigned shift_of(input logic [63:0] vec, input int i);
      return 32'(vec[SW*i +: SW]);
   endfunction
   // Low K bits take only their neighbour's generate; the upper part is a true add seeded by bit K-1
   function automatic logic [31:0] approx_add_ref(input logic [31:0] a, input logic [31:0] b,
                                                  input int w, input int k, input bit approx);
      logic [31:0] mw, lm, lo, hi, cin;
      mw = (32'd1 << w) - 32'd1;
      if (!approx || k == 0) return (a + b) & mw;
      lm = (32'd1 << k) - 32'd1;
      lo = ((a ^ b) ^ ((a & b) << 1)) & lm;
      cin = (a >> (k - 1)) & (b >> (k - 1)) & 32'd1;
      hi = ((a >> k) + (b >> k) + cin) << k;
      return (hi | lo) & mw;
   endfunction
endpackage

// File: rtl/approx_ks_adder.sv
// approx_ks_adder: W-bit Kogge-Stone adder whose K LSBs drop carry propagation when approx_en is set
module approx_ks_adder #(
   parameter int W = 16,
   parameter int K = 6
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         approx_en,
   output logic [W-1:0] sum
);
   localparam int L = $clog2(W);
   logic [W-1:0] p;
   logic [W-2:0] g, pk;
   logic [W-2:0] gl [0:L];
   logic [W-2:0] pl [0:L];
   assign p = a ^ b;
   assign g = a[W-2:0] & b[W-2:0];
   genvar j, l;
   // Killing propagate below K turns the single prefix tree into the approximate carry chain
   for (j = 0; j < W - 1; j++) begin : g_pk
      assign pk[j] = (j < K) ? p[j] & ~approx_en : p[j];
   end
   assign gl[0] = g;
   assign pl[0] = pk;
   for (l = 0; l < L; l++) begin : g_lvl
      for (j = 0; j < W - 1; j++) begin : g_bit
         if (j >= (1 << l)) begin : g_op
            assign gl[l+1][j] = gl[l][j] | (pl[l][j] & gl[l][j-(1<<l)]);
            assign pl[l+1][j] = pl[l][j] & pl[l][j-(1<<l)];
         end else begin : g_pass
            assign gl[l+1][j] = gl[l][j];
            assign pl[l+1][j] = pl[l][j];
         end
      end
   end
   assign sum = p ^ {gl[L], 1'b0};
endmodule

// File: rtl/fir_shift_approx_param.sv
// fir_shift_approx_param: parametrised power-of-two-tap FIR built from a chain of approximate KS adders
module fir_shift_approx_param
   import fir_pkg::*;
#(
   parameter int                    W         = 16,
   parameter int                    NTAPS     = 5,
   parameter logic [SW*NTAPS-1:0]   SHIFT_VEC = SHIFT_DEF,
   parameter int                    K         = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] x,
   input  logic         in_valid,
   input  logic         approx_en,
   input  logic         flush,
   output logic [W-1:0] dataout,
   output logic         out_valid,
   output logic         primed
);
   localparam int CW = $clog2(NTAPS);
   logic [W-1:0] d   [1:NTAPS-1];
   logic [W-1:0] tap [0:NTAPS-1];
   logic [W-1:0] m   [0:NTAPS-1];
   logic [W-1:0] s   [0:NTAPS-1];
   logic [CW-1:0] cnt;
   assign tap[0] = x;
   genvar j;
   for (j = 1; j < NTAPS; j++) begin : g_tap
      assign tap[j] = d[j];
   end
   for (j = 0; j < NTAPS; j++) begin : g_term
      assign m[j] = tap[j] >> shift_of(64'(SHIFT_VEC), j);
   end
   assign s[0] = m[0];
   for (j = 1; j < NTAPS; j++) begin : g_add
      approx_ks_adder #(.W(W), .K(K)) u_add (
         .a         (s[j-1]),
         .b         (m[j]),
         .approx_en (approx_en),
         .sum       (s[j])
      );
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < NTAPS; i++) d[i] <= '0;
         dataout   <= '0;
         out_valid <= 1'b0;
         primed    <= 1'b0;
         cnt       <= '0;
      end else if (flush) begin
         for (int i = 1; i < NTAPS; i++) d[i] <= '0;
         dataout   <= '0;
         out_valid <= 1'b0;
         primed    <= 1'b0;
         cnt       <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            d[1] <= x;
            for (int i = 2; i < NTAPS; i++) d[i] <= d[i-1];
            dataout <= s[NTAPS-1];
            cnt     <= (cnt == CW'(NTAPS - 1)) ? cnt : cnt + 1'b1;
            primed  <= primed | (cnt == CW'(NTAPS - 1));
         end
      end
   end
endmodule

// File: tb/tb_fir_shift_approx_param.sv
// tb_fir_shift_approx_param: directed and random checks of the FIR against an arithmetic reference model
module tb_fir_shift_approx_param;
   import fir_pkg::*;
   localparam int NT = 5;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] x = '0;
   logic        in_valid = 1'b0;
   logic        approx_en = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] dataout;
   logic        out_valid;
   logic        primed;
   int          n_vec = 0;
   int          n_bad = 0;
   int          nacc = 0;
   logic [15:0] last = '0;
   logic [15:0] hist [0:NT-2];
   int          sh [0:NT-1] = '{5, 4, 3, 2, 1};
   int          imp [0:5] = '{32, 64, 128, 256, 512, 0};

   fir_shift_approx_param dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .in_valid  (in_valid),
      .approx_en (approx_en),
      .flush     (flush),
      .dataout   (dataout),
      .out_valid (out_valid),
      .primed    (primed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_vec++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] v, input bit ap);
      logic [31:0] acc;
      acc = 32'(v) >> sh[0];
      for (int i = 1; i < NT; i++) acc = approx_add_ref(acc, 32'(hist[i-1]) >> sh[i], 16, 6, ap);
      return acc[15:0];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NT - 1; i++) hist[i] = '0;
      nacc = 0;
      last = '0;
   endtask

   task automatic send(input logic [15:0] v, input bit ap);
      logic [15:0] e;
      e = model(v, ap);
      @(negedge clk);
      x = v;
      approx_en = ap;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = NT - 2; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = v;
      nacc++;
      last = e;
      chk("dataout", dataout, e);
      chk("out_valid", out_valid, 1);
      chk("primed", primed, nacc >= NT);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         x = 16'($urandom);
         @(posedge clk);
         #1;
         chk("idle_valid", out_valid, 0);
         chk("idle_hold", dataout, last);
      end
   endtask

   initial begin
      clear_model();
      #3 rst = 1'b0;
      #1;
      chk("rst_data", dataout, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_primed", primed, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         send(k == 0 ? 16'h0400 : 16'h0000, 1'b0);
         chk("impulse", dataout, imp[k]);
         chk("impulse_primed", primed, k >= 4);
      end
      repeat (NT) send(16'h0400, 1'b1);
      chk("const400_approx", dataout, 992);
      repeat (NT) send(16'h003F, 1'b0);
      chk("const3f_exact", dataout, 57);
      send(16'h003F, 1'b1);
      chk("const3f_approx", dataout, 21);
      repeat (NT) send(16'hFFFF, 1'b0);
      chk("constffff_exact", dataout, 16'hF7FB);
      idle(3);
      for (int k = 0; k < 40; k++) begin
         send(16'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
      end
      @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1;
      x = 16'($urandom);
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      clear_model();
      chk("flush_data", dataout, 0);
      chk("flush_valid", out_valid, 0);
      chk("flush_primed", primed, 0);
      for (int k = 0; k < 6; k++) begin
         send(k == 0 ? 16'h0400 : 16'h0000, 1'b0);
         chk("impulse2", dataout, imp[k]);
      end
      repeat (NT) send(16'h003F, 1'b0);
      chk("pre_reset_primed", primed, 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_data", dataout, 0);
      chk("async_valid", out_valid, 0);
      chk("async_primed", primed, 0);
      @(negedge clk);
      rst = 1'b1;
      clear_model();
      for (int k = 0; k < NT; k++) begin
         send(16'h003F, 1'b0);
         chk("refill_primed", primed, k == NT - 1);
      end
      chk("refill_data", dataout, 57);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/fir_shift_approx_param.md
Name: fir_shift_approx_param

Overview:
- Parametrised successor to the fixed 5-tap shift-and-add FIR. Taps are power-of-two coefficients implemented as logical right shifts.
- Tap count, data width, shift amounts and approximation depth K are parameters. Sampling is valid-qualified, exact/approximate mode is selectable at run time, and the block has a flush and a warm-up indicator.
- Sits in the FIR datapath evaluation chain. It is the PPA/accuracy trade-off vehicle for the approximate Kogge-Stone adder family.

Parameters:
- W, 16, sample and result width (unsigned).
- NTAPS, 5, number of taps (2..16).
- SHIFT_VEC, {4'd1,4'd2,4'd3,4'd4,4'd5}, packed 4-bit right-shift per tap; tap i uses SHIFT_VEC[4*i+3:4*i]; tap 0 is the newest sample.
- K, 6, approximated LSBs in each adder (0 = exact, must be < W).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- x  in  W  input sample
- in_valid  in  1  x is accepted this cycle
- approx_en  in  1  1 = approximate adders, 0 = exact; sampled with in_valid
- flush  in  1  synchronous clear of delay line, output and fill count
- dataout  out  W  filter result (registered)
- out_valid  out  1  one-cycle pulse, dataout updated
- primed  out  1  delay line holds NTAPS valid samples

Behaviour:
- Reset (rst=0, async):
  - Delay line regs d[1..NTAPS-1] = 0.
  - dataout = 0, out_valid = 0, primed = 0, fill count = 0.
- Delay line:
  - On in_valid, d[1] <= x and d[i] <= d[i-1].
  - Without in_valid, the line holds.
  - Tap 0 is the live x, not a register.
- Terms: m[i] = tap_i >> SHIFT_VEC[i]. Shift is logical, zero-filled, W bits.
- Sum order is fixed: s1 = m0+m1, then s(i) = s(i-1)+m(i), combinational chain of NTAPS-1 adders.
  - Each adder produces W bits. The carry-out is discarded, so the result wraps mod 2^W.
- Adder, approx_en=1, 0-indexed:
  - c[0] = 0.
  - For i < K: c[i+1] = a[i] & b[i] (no propagation).
  - For i >= K: c[i+1] is exact carry propagation seeded by c[K], computed by a Kogge-Stone prefix tree.
  - sum[i] = a[i] ^ b[i] ^ c[i].
- Adder, approx_en=0: every adder is an exact W-bit add.
- Latency: on a cycle with in_valid=1, the next edge loads dataout with the chain result and sets out_valid=1 for exactly one cycle.
  - When in_valid=0, out_valid=0 and dataout holds.
- primed:
  - Fill count saturates at NTAPS-1.
  - primed=1 once NTAPS-1 samples have been accepted since reset or flush. It is registered with dataout, so the first primed output is the NTAPS-th.
  - Outputs before primed are still produced, using zero-filled history.
- flush has priority over in_valid in the same cycle:
  - Clears the line, dataout, out_valid, fill count and primed.
  - The sample presented that cycle is dropped.
- Reset mid-stream: immediate async clear. The first sample after release behaves as after power-up.
- approx_en may change between samples. The mode applies to the whole chain for that sample only; there is no mixed mode within one result.

Decomposition:
- Shared package fir_pkg holds:
  - default SHIFT_VEC
  - a shift-field width constant (4)
  - the function shift_of(vec, i)
  - an approximate reference-model function for the bench
- One sub-module: approx_ks_adder #(W,K), with inputs a, b, approx_en and output sum.
  - Local generate for i<K, KS prefix for i>=K, exact path when approx_en=0.
  - The filter instantiates it NTAPS-1 times in a generate loop.

Test Plan:
- Impulse, exact mode, defaults:
  - Stimulus: x=16'h0400 with in_valid, then 5 zero samples.
  - Required dataout: 32, 64, 128, 256, 512, 0. primed rises with the 5th out_valid.
- Constant 16'h0400, approx_en=1, after fill: dataout = 992. Terms occupy disjoint bits, so approximate equals exact.
- Constant 16'h003F, after fill: exact dataout = 57 (0x0039); approx_en=1, K=6 gives dataout = 21 (0x0015).
- Constant 16'hFFFF, exact, after fill: dataout = 16'hF7FB (63483).
- in_valid gaps and flush:
  - Idle cycles between samples must not shift the line, and out_valid pulses only after valid samples.
  - flush together with in_valid drops the sample and gives dataout=0, primed=0.
  - The next impulse reproduces the first scenario.
- Async reset while primed, asserted mid-cycle:
  - Outputs clear immediately, without waiting for clk.
  - After release, a constant 0x003F exact stream needs 5 samples before primed=1, and the 5th output is 57.
